// File: rtl/layer_priority_mux_if.sv
// Pixel bus between the object drawers and the priority compositor.
// The master modport is the drawer side (drives layer requests and colours);
// the slave modport is the compositor side (returns the merged pixel and
// the per-frame overlap summary).
interface layer_priority_mux_if #(
    parameter int NUM_LAYERS = 5,
    parameter int RGB_W      = 8
);
    logic [NUM_LAYERS-1:0]       draw_req;
    logic [NUM_LAYERS*RGB_W-1:0] rgb_layers;
    logic [RGB_W-1:0]            rgb_background;
    logic [NUM_LAYERS-1:0]       layer_enable;
    logic                        start_of_frame;
    logic [RGB_W-1:0]            RGB;
    logic                        draw_any;
    logic [NUM_LAYERS-1:0]       hit_flags;
    logic                        hit_valid;

    modport master (
        output draw_req,
        output rgb_layers,
        output rgb_background,
        output layer_enable,
        output start_of_frame,
        input  RGB,
        input  draw_any,
        input  hit_flags,
        input  hit_valid
    );

    modport slave (
        input  draw_req,
        input  rgb_layers,
        input  rgb_background,
        input  layer_enable,
        input  start_of_frame,
        output RGB,
        output draw_any,
        output hit_flags,
        output hit_valid
    );
endinterface

// File: rtl/layer_priority_mux.sv
// layer_priority_mux: two-stage priority compositor for the VGA pixel path.
// Layer 0 has the highest priority; when no enabled layer requests the pixel
// the background colour is shown. Alongside the colour, overlaps between the
// ball (layer 0) and every other layer are OR-accumulated over a frame and
// reported as hit_flags on the pixel that starts the next frame.
//
// Build option: define LAYER_MUX_TRANSPARENCY_EN to treat a layer whose
// colour equals TRANSPARENT_COLOR as not requesting the pixel. Without the
// macro, colour values never influence which layer wins.
module layer_priority_mux #(
    parameter int                 NUM_LAYERS        = 5,
    parameter int                 RGB_W             = 8,
    parameter logic [RGB_W-1:0]   TRANSPARENT_COLOR = {RGB_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    layer_priority_mux_if.slave   bus
);

`ifdef LAYER_MUX_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    // Lowest-index requesting layer supplies the colour; background otherwise.
    // Scanning from the top index down lets the lowest index overwrite last.
    function automatic logic [RGB_W-1:0] pick_color(
        input logic [NUM_LAYERS-1:0]       eff,
        input logic [NUM_LAYERS*RGB_W-1:0] layers,
        input logic [RGB_W-1:0]            bg
    );
        logic [RGB_W-1:0] col;
        col = bg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                col = layers[i*RGB_W +: RGB_W];
            end
        end
        return col;
    endfunction

    // Overlap contribution of one pixel: bit 0 flags "ball touches anything",
    // bit i (i>=1) flags "ball touches layer i". With a single layer the shift
    // leaves nothing to overlap with, so the vector is all zero.
    function automatic logic [NUM_LAYERS-1:0] contribution(
        input logic [NUM_LAYERS-1:0] eff
    );
        logic [NUM_LAYERS-1:0] c;
        logic [NUM_LAYERS-1:0] others;
        c      = '0;
        others = eff >> 1;
        c[0]   = eff[0] & (|others);
        for (int i = 1; i < NUM_LAYERS; i++) begin
            c[i] = eff[0] & eff[i];
        end
        return c;
    endfunction

    // Colour-key qualifier; folds to all-zero when transparency is not built in.
    function automatic logic [NUM_LAYERS-1:0] key_mask(
        input logic [NUM_LAYERS*RGB_W-1:0] layers
    );
        logic [NUM_LAYERS-1:0] k;
        k = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            k[i] = TRANSP_EN && (layers[i*RGB_W +: RGB_W] == TRANSPARENT_COLOR);
        end
        return k;
    endfunction

    // Stage 0 -> stage 1 registers
    logic [NUM_LAYERS-1:0] eff_p1_d,     eff_p1_q;
    logic [RGB_W-1:0]      sel_rgb_p1_d, sel_rgb_p1_q;
    logic [NUM_LAYERS-1:0] contrib_p1_d, contrib_p1_q;
    logic                  sof_p1_d,     sof_p1_q;

    // Stage 1 -> stage 2 registers
    logic [RGB_W-1:0]      rgb_p2_d,      rgb_p2_q;
    logic                  draw_any_p2_d, draw_any_p2_q;
    logic [NUM_LAYERS-1:0] acc_d,         acc_q;
    logic [NUM_LAYERS-1:0] hit_flags_d,   hit_flags_q;
    logic                  hit_valid_d,   hit_valid_q;

    // Stage 0: qualify requests, pick the winning colour, form the overlap vector.
    always_comb begin
        eff_p1_d     = bus.draw_req & bus.layer_enable & ~key_mask(bus.rgb_layers);
        sel_rgb_p1_d = pick_color(eff_p1_d, bus.rgb_layers, bus.rgb_background);
        contrib_p1_d = contribution(eff_p1_d);
        sof_p1_d     = bus.start_of_frame;
    end

    // Stage 1 register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eff_p1_q     <= '0;
            sel_rgb_p1_q <= '0;
            contrib_p1_q <= '0;
            sof_p1_q     <= 1'b0;
        end else begin
            eff_p1_q     <= eff_p1_d;
            sel_rgb_p1_q <= sel_rgb_p1_d;
            contrib_p1_q <= contrib_p1_d;
            sof_p1_q     <= sof_p1_d;
        end
    end

    // Stage 1: the start-of-frame pixel opens the new frame, so it seeds the
    // accumulator with its own contribution while the finished frame's
    // accumulator is published. All other pixels just OR into the frame.
    always_comb begin
        rgb_p2_d      = sel_rgb_p1_q;
        draw_any_p2_d = |eff_p1_q;
        hit_valid_d   = sof_p1_q;
        if (sof_p1_q) begin
            hit_flags_d = acc_q;
            acc_d       = contrib_p1_q;
        end else begin
            hit_flags_d = hit_flags_q;
            acc_d       = acc_q | contrib_p1_q;
        end
    end

    // Stage 2 register bank; reset clears any partial frame in acc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_p2_q      <= '0;
            draw_any_p2_q <= 1'b0;
            acc_q         <= '0;
            hit_flags_q   <= '0;
            hit_valid_q   <= 1'b0;
        end else begin
            rgb_p2_q      <= rgb_p2_d;
            draw_any_p2_q <= draw_any_p2_d;
            acc_q         <= acc_d;
            hit_flags_q   <= hit_flags_d;
            hit_valid_q   <= hit_valid_d;
        end
    end

    assign bus.RGB       = rgb_p2_q;
    assign bus.draw_any  = draw_any_p2_q;
    assign bus.hit_flags = hit_flags_q;
    assign bus.hit_valid = hit_valid_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux with a reference model feeding a
// scoreboard queue: every driven pixel pushes its expected output, which is
// popped and compared two clock edges later.
module tb_layer_priority_mux;
    localparam int N = 5;
    localparam int W = 8;

    logic clk;
    logic reset;

    layer_priority_mux_if #(.NUM_LAYERS(N), .RGB_W(W)) bus ();

    layer_priority_mux #(
        .NUM_LAYERS       (N),
        .RGB_W            (W),
        .TRANSPARENT_COLOR(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rgb;
        logic         da;
        logic [N-1:0] hf;
        logic         hv;
        string        tag;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [N*W-1:0] lay_v;
    logic [W-1:0]   bg_v;
    logic [N-1:0]   acc_m;
    logic [N-1:0]   hf_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, ".rgb"},  32'(bus.RGB),       32'(e.rgb));
        check({e.tag, ".da"},   32'(bus.draw_any),  32'(e.da));
        check({e.tag, ".hf"},   32'(bus.hit_flags), 32'(e.hf));
        check({e.tag, ".hv"},   32'(bus.hit_valid), 32'(e.hv));
    endtask

    // Drive one pixel, model it, and check the pixel driven one cycle earlier.
    task automatic pixel(input logic [N-1:0] req, input logic [N-1:0] en,
                         input logic sof, input string tag);
        logic [N-1:0] eff;
        logic [N-1:0] c;
        logic         found;
        exp_t         e;
        bus.draw_req       = req;
        bus.layer_enable   = en;
        bus.start_of_frame = sof;
        bus.rgb_layers     = lay_v;
        bus.rgb_background = bg_v;

        eff = req & en;
`ifdef LAYER_MUX_TRANSPARENCY_EN
        for (int i = 0; i < N; i++)
            if (lay_v[i*W +: W] == 8'hFF) eff[i] = 1'b0;
`endif
        found = 1'b0;
        e.rgb = bg_v;
        for (int i = 0; i < N; i++) begin
            if (!found && eff[i]) begin
                e.rgb = lay_v[i*W +: W];
                found = 1'b1;
            end
        end
        e.da = found;
        c = '0;
        if (eff[0]) begin
            c = eff;
            c[0] = ((eff >> 1) != '0);
        end
        if (sof) begin
            hf_m  = acc_m;
            acc_m = c;
        end else begin
            acc_m = acc_m | c;
        end
        e.hf  = hf_m;
        e.hv  = sof;
        e.tag = tag;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() >= 2) compare_front();
    endtask

    // Hold reset for some cycles with random inputs; outputs must stay zero.
    task automatic hold_reset(input int cycles);
        reset = 1'b1;
        #1;
        check("rst_async.rgb", 32'(bus.RGB), 32'h0);
        for (int k = 0; k < cycles; k++) begin
            bus.draw_req       = N'($urandom);
            bus.layer_enable   = N'($urandom);
            bus.start_of_frame = 1'($urandom);
            bus.rgb_layers     = (N*W)'({$urandom, $urandom});
            bus.rgb_background = W'($urandom);
            @(posedge clk);
            #1;
            check("rst.rgb", 32'(bus.RGB),       32'h0);
            check("rst.da",  32'(bus.draw_any),  32'h0);
            check("rst.hf",  32'(bus.hit_flags), 32'h0);
            check("rst.hv",  32'(bus.hit_valid), 32'h0);
        end
        reset = 1'b0;
        sb_q.delete();
        acc_m = '0;
        hf_m  = '0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.draw_req       = '0;
        bus.layer_enable   = '0;
        bus.start_of_frame = 1'b0;
        bus.rgb_layers     = '0;
        bus.rgb_background = '0;
        acc_m = '0;
        hf_m  = '0;
        lay_v = {8'h44, 8'h33, 8'hE0, 8'h1C, 8'h11};
        bg_v  = 8'h03;

        @(posedge clk);
        #1;
        hold_reset(3);

        // Priority: layer 1 beats layer 2 and 4.
        pixel(5'b00000, 5'b11111, 1'b0, "idle0");
        pixel(5'b10110, 5'b11111, 1'b0, "prio");
        pixel(5'b11111, 5'b11111, 1'b0, "prio_all");

        // Mask and background, then re-enable layer 0.
        pixel(5'b00001, 5'b11110, 1'b0, "mask_bg");
        pixel(5'b00001, 5'b11111, 1'b0, "reenable");

        // Collision frame, then a clean frame.
        pixel(5'b00000, 5'b11111, 1'b1, "coll_sof1");
        pixel(5'b01001, 5'b11111, 1'b0, "coll_pix");
        pixel(5'b00000, 5'b11111, 1'b1, "coll_sof2");
        pixel(5'b00010, 5'b11111, 1'b0, "clean_pix");
        pixel(5'b00000, 5'b11111, 1'b1, "clean_sof");

        // Transparency key on layer 0.
        lay_v[0 +: W] = 8'hFF;
        lay_v[W +: W] = 8'h40;
        pixel(5'b00011, 5'b11111, 1'b0, "transp");
        pixel(5'b00000, 5'b11111, 1'b1, "transp_sof");
        lay_v = {8'h44, 8'h33, 8'hE0, 8'h1C, 8'h11};

        // Reset mid-frame discards the partial accumulation.
        pixel(5'b10001, 5'b11111, 1'b0, "pre_rst1");
        pixel(5'b00101, 5'b11111, 1'b0, "pre_rst2");
        hold_reset(3);
        pixel(5'b00100, 5'b11111, 1'b0, "post_rst1");
        pixel(5'b01000, 5'b11111, 1'b0, "post_rst2");
        pixel(5'b00000, 5'b11111, 1'b1, "post_rst_sof");

        // Back-to-back start_of_frame pulses.
        pixel(5'b00101, 5'b11111, 1'b1, "b2b_sof1");
        pixel(5'b00000, 5'b11111, 1'b1, "b2b_sof2");
        pixel(5'b00000, 5'b11111, 1'b0, "b2b_tail");

        // Mixed random pixels, including keyed colours.
        for (int k = 0; k < 40; k++) begin
            lay_v = (N*W)'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) lay_v[$urandom_range(0, N-1)*W +: W] = 8'hFF;
            bg_v = W'($urandom);
            pixel(N'($urandom), N'($urandom), ($urandom_range(0, 4) == 0), "rand");
        end

        // Drain the pipeline.
        pixel(5'b00000, 5'b11111, 1'b0, "flush1");
        pixel(5'b00000, 5'b11111, 1'b0, "flush2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_priority_mux.md
# layer_priority_mux

Parametrised, pipelined priority compositor for the VGA pixel path. It merges NUM_LAYERS object layers (ball, flippers, score, obstacles, …) over a background colour into one RGB pixel. It also accumulates per-frame overlap flags between the top layer (ball) and every other layer for the game logic. It sits between the object drawers and the VGA output stage and adds a fixed 2-cycle latency.

## Interface
Parameters:
- NUM_LAYERS, 5, number of object layers; index 0 has highest priority (1..32)
- RGB_W, 8, colour width per pixel
- TRANSPARENT_COLOR, 8'hFF (RGB_W bits), colour key used only when transparency is compiled in

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- draw_req  in  NUM_LAYERS  per-layer "pixel is inside object" request; bit i is layer i
- rgb_layers  in  NUM_LAYERS*RGB_W  layer colours; layer i occupies bits [i*RGB_W +: RGB_W]
- rgb_background  in  RGB_W  colour used when no layer wins
- layer_enable  in  NUM_LAYERS  per-layer mask; 0 forces the layer to be ignored
- start_of_frame  in  1  one-cycle pulse, aligned with the first pixel of a frame
- RGB  out  RGB_W  composited pixel
- draw_any  out  1  1 when some layer won the pixel RGB is showing
- hit_flags  out  NUM_LAYERS  overlap summary of the previous complete frame
- hit_valid  out  1  one-cycle pulse when hit_flags updates

## Operation
- Effective request: eff[i] = draw_req[i] & layer_enable[i], plus the transparency qualifier when it is compiled in.
- Winner: the lowest index i with eff[i]=1. Output colour is rgb_layers slice i. If eff is 0, the output is rgb_background and draw_any=0.
- Pixel contribution vector c, computed from eff of the same pixel:
  - c[0] = eff[0] & |eff[NUM_LAYERS-1:1]
  - c[i] = eff[0] & eff[i] for i ≥ 1
  - NUM_LAYERS=1 gives c=0.
- Accumulator acc (NUM_LAYERS bits, internal) holds the OR of c over the current frame.
- Frame boundary: the pixel that carries start_of_frame belongs to the new frame. At that pixel:
  - hit_flags <= acc, which is the old frame's result
  - acc <= c of that pixel
  - hit_valid pulses
- On every other pixel: acc <= acc | c, and hit_flags holds.
- layer_enable and draw_req are sampled on the same edge; mask changes have no extra delay.
- Back-to-back start_of_frame pulses are legal. Each pulse latches, and a one-pixel frame reports that pixel's c.

## Timing
- Stage 1, edge n+1 after inputs are presented at cycle n: registers eff, the selected colour, the winner flag, c and start_of_frame.
- Stage 2, edge n+2: updates RGB, draw_any, acc, hit_flags and hit_valid.
- Latency is exactly 2 cycles for every output, including the hit_valid pulse relative to start_of_frame.
- Throughput is one pixel per cycle. There is no back-pressure and no stall.
- Reset, asynchronous and active-high, sets every register to 0: RGB=0, draw_any=0, hit_flags=0, hit_valid=0, acc=0, and all stage-1 registers.
- Reset mid-frame discards acc. The first start_of_frame after reset reports only the pixels seen since reset was released.
- While reset is held, outputs stay 0 regardless of inputs.

## Configuration
- LAYER_MUX_TRANSPARENCY_EN defined:
  - A layer whose colour slice equals TRANSPARENT_COLOR is treated as eff[i]=0.
  - It neither wins nor contributes to c, so lower-priority layers and the background show through.
- Not defined: colour values never affect eff. TRANSPARENT_COLOR is unused, and a layer drawing 8'hFF outputs 8'hFF.

## Test plan
- Priority: NUM_LAYERS=5, draw_req=5'b10110, all enabled, layer1=8'h1C, layer2=8'hE0 -> RGB=8'h1C, draw_any=1, exactly 2 cycles later.
- Mask/background: draw_req=5'b00001, layer_enable=5'b11110, background=8'h03 -> RGB=8'h03, draw_any=0. Re-enabling layer 0 shows layer0 colour on the next pixel's output.
- Collision frame: start_of_frame, then one pixel with draw_req=5'b01001, then start_of_frame -> hit_flags=5'b01001 with a single hit_valid pulse 2 cycles after the second start_of_frame. A following clean frame reports 5'b00000.
- Transparency: macro defined, draw_req=5'b00011, layer0=8'hFF, layer1=8'h40 -> RGB=8'h40 and c=0. Macro undefined -> RGB=8'hFF and hit_flags bits 0 and 1 set at the next frame.
- Reset mid-frame: overlap pixels, then assert reset for 3 cycles, then a clean frame to start_of_frame -> all outputs 0 during reset, and the reported hit_flags=0.
- Back-to-back start_of_frame: pulses on 2 consecutive cycles, the first carrying draw_req=5'b00101 -> two hit_valid pulses. The second reports 5'b00101.
